// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bus between the decoder (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TW     = 3
);
    localparam int unsigned SW = $clog2(NSTAGE + 1);

    logic [4:0]    rs_d;
    logic [4:0]    rt_d;
    logic [TW-1:0] tuse_rs_d;
    logic [TW-1:0] tuse_rt_d;
    logic [4:0]    a3_d;
    logic          rfwe_d;
    logic [TW-1:0] tnew_d;
    logic          md_start_d;
    logic          md_div_d;
    logic          md_use_d;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;
    logic          md_busy;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, rfwe_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, rfwe_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse scoreboard for the five-stage pipeline: tracks in-flight writers,
// produces the D-stage stall and forward selects, and counts down the mult/div unit.
module hazard_scoreboard #(
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned TW      = 3,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   sb
);
    localparam int unsigned SW     = $clog2(NSTAGE + 1);
    localparam int unsigned MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW     = $clog2(MD_MAX + 1);

    logic          ent_valid [1:NSTAGE];
    logic [4:0]    ent_a3    [1:NSTAGE];
    logic [TW-1:0] ent_tnew  [1:NSTAGE];
    logic [CW-1:0] md_cnt;

    logic          rs_hit_c, rt_hit_c;
    logic [SW-1:0] rs_k_c, rt_k_c;
    logic [TW-1:0] rs_tnew_c, rt_tnew_c;
    logic          md_busy_c;
    logic          stall_c;

    // Scan oldest to youngest so the youngest matching writer overrides older ones.
    always_comb begin
        rs_hit_c  = 1'b0;
        rs_k_c    = '0;
        rs_tnew_c = '0;
        rt_hit_c  = 1'b0;
        rt_k_c    = '0;
        rt_tnew_c = '0;
        for (int k = int'(NSTAGE); k >= 1; k--) begin
            if (ent_valid[k] && (ent_a3[k] == sb.rs_d) && (sb.rs_d != 5'd0)) begin
                rs_hit_c  = 1'b1;
                rs_k_c    = SW'(k);
                rs_tnew_c = ent_tnew[k];
            end
            if (ent_valid[k] && (ent_a3[k] == sb.rt_d) && (sb.rt_d != 5'd0)) begin
                rt_hit_c  = 1'b1;
                rt_k_c    = SW'(k);
                rt_tnew_c = ent_tnew[k];
            end
        end
    end

    assign md_busy_c = (md_cnt != '0);
    assign stall_c   = (rs_hit_c && (rs_tnew_c > sb.tuse_rs_d))
                     | (rt_hit_c && (rt_tnew_c > sb.tuse_rt_d))
                     | (sb.md_use_d && md_busy_c);

    assign sb.stall      = stall_c;
    assign sb.md_busy    = md_busy_c;
    assign sb.fwd_rs_sel = (rs_hit_c && (rs_tnew_c == '0)) ? rs_k_c : '0;
    assign sb.fwd_rt_sel = (rt_hit_c && (rt_tnew_c == '0)) ? rt_k_c : '0;

    // Writer pipeline advances every cycle; a stalled D slot enters E as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                ent_valid[k] <= 1'b0;
                ent_a3[k]    <= '0;
                ent_tnew[k]  <= '0;
            end
            md_cnt <= '0;
        end else begin
            ent_valid[1] <= sb.rfwe_d && (sb.a3_d != 5'd0) && !stall_c;
            ent_a3[1]    <= sb.a3_d;
            ent_tnew[1]  <= sb.tnew_d;
            for (int k = 2; k <= int'(NSTAGE); k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_a3[k]    <= ent_a3[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end
            if (sb.md_start_d && !stall_c) begin
                md_cnt <= sb.md_div_d ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU forwarding, youngest-wins,
// $0, mult/div busy and asynchronous reset, with hand-computed expectations.
module tb_hazard_scoreboard;
    localparam int unsigned NSTAGE = 3;
    localparam int unsigned TW     = 3;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE), .TW(TW)) sb ();

    hazard_scoreboard #(.NSTAGE(NSTAGE), .TW(TW), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk3(input string tag, input int st, input int frs, input int frt);
        chk({tag, ".stall"}, 32'(sb.stall), st);
        chk({tag, ".fwd_rs"}, 32'(sb.fwd_rs_sel), frs);
        chk({tag, ".fwd_rt"}, 32'(sb.fwd_rt_sel), frt);
    endtask

    task automatic drive(input int rs, input int rt, input int tu_rs, input int tu_rt,
                         input int a3, input int we, input int tn,
                         input int mds, input int mdd, input int mdu);
        sb.rs_d       = 5'(rs);
        sb.rt_d       = 5'(rt);
        sb.tuse_rs_d  = TW'(tu_rs);
        sb.tuse_rt_d  = TW'(tu_rt);
        sb.a3_d       = 5'(a3);
        sb.rfwe_d     = 1'(we);
        sb.tnew_d     = TW'(tn);
        sb.md_start_d = 1'(mds);
        sb.md_div_d   = 1'(mdd);
        sb.md_use_d   = 1'(mdu);
    endtask

    task automatic idle();
        drive(0, 0, 4, 4, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (NSTAGE + 1) tick();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        idle();
        #2;
        chk3("reset", 0, 0, 0);
        chk("reset.md_busy", 32'(sb.md_busy), 0);
        tick();
        reset = 1'b1;

        // Load-use: lw $1 (tnew 2) then beq $1 (tuse 0)
        drive(0, 0, 4, 4, 1, 1, 2, 0, 0, 0);
        #1 chk3("lu.lw", 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk3("lu.c1", 1, 0, 0);
        tick();
        #1 chk3("lu.c2", 1, 0, 0);
        tick();
        #1 chk3("lu.c3", 0, 3, 0);
        drain();

        // ALU-ALU: addu $2 (tnew 1) then addu $3,$2,$4 (tuse 1)
        drive(0, 0, 4, 4, 2, 1, 1, 0, 0, 0);
        #1 chk3("alu.w", 0, 0, 0);
        tick();
        drive(2, 4, 1, 1, 3, 1, 1, 0, 0, 0);
        #1 chk3("alu.d", 0, 0, 0);
        tick();
        idle();
        #1 chk3("alu.after", 0, 0, 0);
        drain();

        // E-stage forward on rt: lui $7 (tnew 0) then consumer rt=$7 tuse 0
        drive(0, 0, 4, 4, 7, 1, 0, 0, 0, 0);
        tick();
        drive(0, 7, 4, 0, 0, 0, 0, 0, 0, 0);
        #1 chk3("rtfwd", 0, 0, 1);
        drain();

        // Youngest wins: lui $5 (tnew 0), ori $5 (tnew 1), beq $5,$0
        drive(0, 0, 4, 4, 5, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 4, 4, 5, 1, 1, 0, 0, 0);
        #1 chk3("yw.ori", 0, 0, 0);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk3("yw.c1", 1, 0, 0);
        tick();
        #1 chk3("yw.c2", 0, 2, 0);
        drain();

        // Zero register: writer a3=0 tnew 2, consumer rs=rt=0 tuse 0
        drive(0, 0, 4, 4, 0, 1, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk3("zero", 0, 0, 0);
        drain();

        // mult then mflo: 5 stalled busy cycles then release
        drive(0, 0, 4, 4, 0, 0, 0, 1, 0, 1);
        #1 chk3("mul.issue", 0, 0, 0);
        chk("mul.issue.busy", 32'(sb.md_busy), 0);
        tick();
        drive(0, 0, 4, 4, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mflo.stall", 32'(sb.stall), 1);
            chk("mflo.busy", 32'(sb.md_busy), 1);
            tick();
        end
        #1 chk("mflo.rel.stall", 32'(sb.stall), 0);
        chk("mflo.rel.busy", 32'(sb.md_busy), 0);
        tick();

        // div presented during mult busy is held, then runs 10 cycles
        drive(0, 0, 4, 4, 0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 4, 4, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("div.held.stall", 32'(sb.stall), 1);
            chk("div.held.busy", 32'(sb.md_busy), 1);
            tick();
        end
        #1 chk("div.issue.stall", 32'(sb.stall), 0);
        chk("div.issue.busy", 32'(sb.md_busy), 0);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            #1 chk("div.busy", 32'(sb.md_busy), 1);
            tick();
        end
        #1 chk("div.done", 32'(sb.md_busy), 0);
        drain();

        // Reset mid load-use stall with mult busy
        drive(0, 0, 4, 4, 0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 4, 4, 1, 1, 2, 0, 0, 0);
        #1 chk("rst.pre.busy", 32'(sb.md_busy), 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk3("rst.pre", 1, 0, 0);
        #2 reset = 1'b0;
        #1 chk3("rst.async", 0, 0, 0);
        chk("rst.async.busy", 32'(sb.md_busy), 0);
        tick();
        #1 chk3("rst.held", 0, 0, 0);
        reset = 1'b1;
        sb.md_use_d = 1'b1;
        #1 chk3("rst.rel", 0, 0, 0);
        tick();
        #1 chk3("rst.rel2", 0, 0, 0);
        chk("rst.rel2.busy", 32'(sb.md_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-instruction Tuse/Tnew decode: a sequential scoreboard for the five-stage MIPS pipeline (F/D/E/M/W).
- Tracks each in-flight register writer's destination and remaining Tnew through NSTAGE post-decode stages.
- Generates the D-stage stall and D-stage forwarding selects, and models a multi-cycle mult/div unit with a busy countdown.
- Sits beside the D-stage decoder: consumes its A3/Tuse/Tnew outputs, drives the pipeline-register enables.

Parameters:
- NSTAGE, 3, number of tracked stages after D (1=E, 2=M, 3=W).
- TW, 3, width of Tuse/Tnew fields.
- MUL_LAT, 5, mult/multu busy cycles.
- DIV_LAT, 10, div/divu busy cycles.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; state clears while reset==0.
- rs_d  in  5  D-stage rs field.
- rt_d  in  5  D-stage rt field.
- tuse_rs_d  in  TW  cycles until rs is needed (0 = in D).
- tuse_rt_d  in  TW  same for rt.
- a3_d  in  5  destination register.
- rfwe_d  in  1  D instruction writes the register file.
- tnew_d  in  TW  cycles after entering E until the result exists.
- md_start_d  in  1  D instruction is mult/multu/div/divu.
- md_div_d  in  1  with md_start_d: selects DIV_LAT, else MUL_LAT.
- md_use_d  in  1  D instruction touches HI/LO or the md unit (mf*, mt*, mult, div).
- stall  out  1  freeze PC and F/D; insert bubble into E.
- fwd_rs_sel  out  $clog2(NSTAGE+1)  D-stage rs forward source: 0=RF, k=stage k.
- fwd_rt_sel  out  $clog2(NSTAGE+1)  same for rt.
- md_busy  out  1  md countdown nonzero.

Behaviour:
- State:
  - NSTAGE entries {valid, a3, tnew}; entry 1 is E.
  - md counter, width wide enough for max(MUL_LAT, DIV_LAT).
- Reset (reset==0, asynchronous): all valid=0, counter=0. Hence stall=0, fwd sels=0, md_busy=0 immediately and for as long as reset is held. Reset mid-stall or mid-busy drops everything with no residue.
- Per rising edge, reset high:
  - entry[k+1] <= entry[k], with tnew decremented saturating at 0.
  - Last entry is discarded.
  - entry[1] <= {rfwe_d && a3_d!=0 && !stall, a3_d, tnew_d}. A stalled cycle loads a bubble (valid=0).
- Match rule for source s (rs or rt):
  - Youngest k with valid && a3==s && s!=0 is the match.
  - Older matches are ignored.
  - s==0 never matches.
- Register stall (combinational): the match exists && match.tnew > tuse_s. Tuse values ≥ any reachable Tnew (e.g. 4 = "unused") never stall.
- Forwarding (combinational):
  - fwd_s_sel = k if the match exists and match.tnew==0, else 0.
  - These selects are valid only for D consumers. Later-stage forwarding is out of scope.
- md unit:
  - Issue happens on the edge where md_start_d && !stall: counter <= md_div_d ? DIV_LAT : MUL_LAT.
  - Otherwise the counter decrements to 0 and holds.
  - md_busy = counter!=0.
  - md stall = md_use_d && md_busy. This covers back-to-back mult and mult→mflo.
- stall = rs stall | rt stall | md stall. stall is purely combinational from current state and D inputs, with no registered delay.
- Simultaneous events:
  - A stall blocks md issue in the same cycle.
  - A bubble never matches.
  - Entries keep advancing during stall; only entry 1 is bubbled.

Test Plan:
- Load-use: lw $1 (tnew 2) then beq $1 (tuse_rs 0).
  - Required: stall=1 for exactly 2 cycles.
  - On the third cycle: stall=0, fwd_rs_sel=3.
- ALU-ALU: addu $2 (tnew 1) then addu $3,$2,$4 (tuse 1).
  - Required: stall=0 every cycle, fwd_rs_sel=0 in D.
- Youngest-wins: setup is E holds ori $5 (tnew 1) and M holds lui $5 (tnew 0); D is beq $5,$0.
  - Required: stall=1; fwd_rs_sel is not 2.
  - Next cycle: stall=0, fwd_rs_sel=2.
- Zero register: writer with a3=0, tnew 2; consumer rs=0, tuse 0.
  - Required: stall=0, fwd_rs_sel=0.
- md, MUL_LAT=5: mult issues; mflo follows in D.
  - Required: md_busy=1 and stall=1 for exactly 5 cycles, then release.
  - A div issued during busy is held until busy clears, then md_busy=1 for 10 cycles.
- Reset: drive reset=0 mid-load-use-stall, between clock edges.
  - Required: stall, fwd sels and md_busy all 0 before the next edge.
  - After reset=1 with no new writers: no stall.
